// File: rtl/main_controller.sv
// Multicycle processor main control FSM.
// Walks each instruction through fetch, decode and execute states. Outputs are
// decoded from the current state, qualified by mem_ready and zero where needed.
//
//   state   | code | meaning
//   FETCH   |  0   | read instruction, PC+4; waits on mem_ready
//   DECODE  |  1   | register read, branch target precompute
//   MEMADR  |  2   | lw/sw effective address
//   MEMRD   |  3   | data read; waits on mem_ready
//   MEMWB   |  4   | load result to register file
//   MEMWR   |  5   | data write; waits on mem_ready
//   EXECUTE |  6   | R-type ALU operation
//   ALUWB   |  7   | R-type result to rd
//   BRANCH  |  8   | beq compare, PC update on zero
//   IEXEC   |  9   | I-type ALU operation
//   IWB     | 10   | I-type result to rt
//   JUMP    | 11   | PC <- jump target
module main_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t cur;
    logic   pcwrite;
    logic   branch;
    logic   legal;

    // State register and next-state selection; unused codes fall back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:   if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:                     cur <= S_MEMADR;
                        OP_RTYPE:                         cur <= S_EXECUTE;
                        OP_BEQ:                           cur <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur <= S_IEXEC;
                        OP_J:                             cur <= S_JUMP;
                        default:                          cur <= S_FETCH;
                    endcase
                end
                S_MEMADR:  cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) cur <= S_MEMWB;
                S_MEMWR:   if (mem_ready) cur <= S_FETCH;
                S_EXECUTE: cur <= S_ALUWB;
                S_IEXEC:   cur <= S_IWB;
                default:   cur <= S_FETCH;
            endcase
        end
    end

    // Opcode support check, used only to flag unsupported instructions in DECODE.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
    end

    // Moore output decode; strobes are gated by rst_n so nothing writes while in reset.
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready & rst_n;
                pcwrite = mem_ready & rst_n;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~legal & rst_n;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = rst_n;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_ready & rst_n;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b11;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = rst_n;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = rst_n;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b10;
            end
            S_IWB:     regwrite = rst_n;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = rst_n;
            end
            default: begin
                alusrcb = 2'b01;
            end
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = cur;

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- opcode  in  6  instr[31:26] from instruction register; stable after FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- irwrite, memwrite, regwrite  out  1 each  write strobes
- iord, alusrca, regdst, memtoreg  out  1 each  datapath mux selects
- alusrcb  out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  2  to ALU control: 00 add, 01 sub, 10 decode by opcode, 11 decode by funct
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Function
REQ-003 SHALL be a Moore FSM; all outputs SHALL decode from the state register (plus zero and mem_ready where noted), with no output latency beyond that.
REQ-004 State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-005 FETCH SHALL hold while mem_ready=0, then go to DECODE.
REQ-006 DECODE SHALL go to:
- MEMADR for 100011 (lw) and 101011 (sw)
- EXECUTE for 000000 (R-type)
- BRANCH for 000100 (beq)
- IEXEC for 001000, 001100, 001101, 001010 (addi, andi, ori, slti)
- JUMP for 000010 (j)
- FETCH for any other opcode, with illegal_op=1 for that DECODE cycle only
REQ-007 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-008 MEMRD and MEMWR SHALL hold while mem_ready=0. MEMRD then goes to MEMWB; MEMWR then goes to FETCH.
REQ-009 The following transitions SHALL be unconditional: MEMWB->FETCH, EXECUTE->ALUWB, ALUWB->FETCH, BRANCH->FETCH, IEXEC->IWB, IWB->FETCH, JUMP->FETCH.
REQ-010 Every output not listed for a state SHALL be 0 in that state. Per-state outputs:
- FETCH: alusrcb=01; irwrite=pcwrite=mem_ready
- DECODE: alusrcb=11
- MEMADR: alusrca=1, alusrcb=10
- MEMRD: iord=1
- MEMWB: memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=mem_ready
- EXECUTE: alusrca=1, aluop=11
- ALUWB: regdst=1, regwrite=1
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1
- IEXEC: alusrca=1, alusrcb=10, aluop=10
- IWB: regwrite=1
- JUMP: pcsrc=10, pcwrite=1
REQ-011 pcen SHALL equal pcwrite OR (branch AND zero), combinationally in the same cycle.
REQ-012 Each write strobe SHALL assert for exactly one cycle per instruction.
REQ-013 Per-instruction cycle counts with mem_ready held at 1:
- lw: 5
- sw: 4
- R-type: 4
- I-type ALU: 4
- beq: 3
- j: 3
REQ-014 Each mem_ready=0 cycle SHALL add one cycle, with no output change while waiting.

Reset
REQ-015 rst_n low SHALL force state=FETCH immediately, independent of clk.
REQ-016 While rst_n is low, irwrite, pcwrite, pcen, memwrite, regwrite and illegal_op SHALL be 0; all other outputs SHALL take their FETCH values.
REQ-017 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-018 The first FETCH edge after rst_n rises SHALL be the first clk edge where rst_n=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- lw (100011), mem_ready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; pcen=1 only in state 0.
- sw, mem_ready=0 for 3 cycles in MEMWR: state 5 held 4 cycles; memwrite=1 only on the final cycle.
- beq, zero=1 then zero=0: BRANCH gives pcen=1, pcsrc=01, aluop=01 only when zero=1.
- ori (001101) then R-type: aluop=10 in IEXEC; aluop=11 in EXECUTE; regdst=0 in IWB; regdst=1 in ALUWB.
- opcode 111111: illegal_op pulses once in DECODE; next state 0; no write strobe asserted.
- rst_n pulsed low in MEMRD: state=0 immediately; all strobes 0 while low; clean fetch afterwards.
